bus_sync_en: RTL and testbench
==============================

// Module: bus_sync_en
// PURPOSE
//  Destination-domain multi-bit CDC synchroniser, qualified by an enable.
//  - Only bus_enable passes through an NUM_STAGES flop chain; unsync_bus is never synchronised bit-by-bit.
//  - unsync_bus is captured on a detected enable event (level-rise or toggle mode).
//  - The captured word is offered through a valid/ready handshake; an overrun flag and a load counter are kept.
//  - Sits at the receive side of every UART->SYS and SYS->UART bus crossing.
// PARAMETERS
//  WIDTH       8   data bus width (>=1)
//  NUM_STAGES  2   enable synchroniser depth (>=2)
//  EN_MODE     0   0 = event on rising edge of sync'd enable; 1 = event on any edge (toggle)
//  CNT_W       8   width of the saturating load counter
// PORTS
//  clk           in   1        destination clock
//  reset_n       in   1        asynchronous, active-low reset
//  unsync_bus    in   WIDTH    source-domain data; source holds it stable (see BEHAVIOUR)
//  bus_enable    in   1        source-domain qualifier (level or toggle per EN_MODE)
//  sync_ready    in   1        consumer accepts sync_bus when sync_valid=1
//  clr_ovr       in   1        synchronous clear of overrun
//  sync_bus      out  WIDTH    captured data, held until the next load
//  sync_valid    out  1        sync_bus holds an unconsumed word
//  enable_pulse  out  1        one-cycle strobe, coincident with each load
//  overrun       out  1        sticky: an event was dropped because the word was not consumed
//  event_cnt     out  CNT_W    number of loads since reset, saturates at all-ones
// BEHAVIOUR
//  Reset (async assert, sync release):
//  - en_sync chain, en_d, sync_bus, sync_valid, enable_pulse, overrun, event_cnt all reset to 0.
//  Enable synchroniser:
//  - en_sync[0] <= bus_enable; en_sync[i] <= en_sync[i-1]; en_s = en_sync[NUM_STAGES-1].
//  - en_d <= en_s every cycle.
//  - event = EN_MODE==0 ? (en_s & ~en_d) : (en_s ^ en_d). Combinational, internal only.
//  Latency:
//  - Edge 1 is the first clk edge sampling the new bus_enable level.
//  - event is high during the cycle after edge NUM_STAGES.
//  - Load occurs at edge NUM_STAGES+1.
//  Source obligation:
//  - unsync_bus stable from 1 clk before the enable change until edge NUM_STAGES+2.
//  - Minimum enable event spacing is 2 clk.
//  Load rule (each edge, evaluated in order):
//  - consume = sync_valid & sync_ready
//  - load    = event & (~sync_valid | sync_ready)
//  - drop    = event & sync_valid & ~sync_ready
//  Register updates on those terms:
//  - load: sync_bus <= unsync_bus; sync_valid <= 1; enable_pulse <= 1; event_cnt <= sat(event_cnt+1).
//  - consume without load: sync_valid <= 0.
//  - drop: sync_bus and sync_valid unchanged; enable_pulse <= 0; overrun <= 1.
//  - enable_pulse is 0 in every cycle without a load.
//  Boundary and simultaneous cases:
//  - consume and event in the same cycle: new word loaded, sync_valid stays 1, no overrun.
//  - clr_ovr and drop in the same cycle: overrun stays 1 (set wins).
//  - event_cnt at all-ones: holds; loads still occur.
//  - EN_MODE=0: falling edge of en_s produces no event.
//  - EN_MODE=1: the source toggle must start at 0 after reset.
//  - Reset asserted mid-operation: all state clears immediately; an in-flight enable edge is lost.
//    If bus_enable is still high at release in EN_MODE=0, its rise is seen again NUM_STAGES+1 edges later
//    (re-capture is intended).
//  - Glitch on bus_enable shorter than 1 clk: may be missed; spec requires a source pulse >= 1 dest clk + setup.
// TESTING
//  T1 (lat):   NUM_STAGES=2, EN_MODE=0, bus=8'hA5, bus_enable 0->1 sampled at edge 1 ->
//              enable_pulse=1 and sync_bus=8'hA5 exactly after edge 3, sync_valid=1, event_cnt=1.
//  T2 (level): hold bus_enable=1 for 20 cycles, then 0 -> exactly one load; no event on the fall.
//  T3 (toggle): EN_MODE=1; toggle bus_enable 4x with data 11,22,33,44, sync_ready=1 ->
//               4 pulses, data in order, event_cnt=4.
//  T4 (ovr):   sync_ready=0, two events (data 8'h11 then 8'h22) ->
//              sync_bus stays 8'h11, overrun=1; clr_ovr alone clears it; clr_ovr+drop same cycle keeps 1.
//  T5 (simul): event in same cycle as consume -> sync_valid stays 1, new data loaded, overrun=0.
//  T6 (reset): assert reset_n=0 one cycle after the enable edge -> all outputs 0, no load after release
//              in EN_MODE=1; CNT_W=2 saturates at 3 after 5 loads.

Source files
------------

// File: rtl/bus_sync_en.sv
// bus_sync_en: receive-side multi-bit CDC capture.
// Only the enable qualifier is synchronised. When a synchronised enable
// event is seen, the quasi-static source bus is sampled, and the word is
// offered through a valid/ready handshake. An overrun flag records dropped
// events, and a saturating counter records the number of loads.
module bus_sync_en #(
  parameter int WIDTH      = 8,
  parameter int NUM_STAGES = 2,
  parameter int EN_MODE    = 0,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] unsync_bus,
  input  logic             bus_enable,
  input  logic             sync_ready,
  input  logic             clr_ovr,
  output logic [WIDTH-1:0] sync_bus,
  output logic             sync_valid,
  output logic             enable_pulse,
  output logic             overrun,
  output logic [CNT_W-1:0] event_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Enable synchroniser chain; stage 0 is the only flop that sees the async input.
  logic [NUM_STAGES-1:0] en_sync_q;
  logic                  en_s;
  logic                  en_d_q;
  logic                  evt;

  // Enable synchroniser chain, built one flop per stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_sync_q[0] <= 1'b0;
    end else begin
      en_sync_q[0] <= bus_enable;
    end
  end

  for (genvar gi = 1; gi < NUM_STAGES; gi++) begin : g_sync
    // Each later stage re-samples the previous one to resolve metastability.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        en_sync_q[gi] <= 1'b0;
      end else begin
        en_sync_q[gi] <= en_sync_q[gi-1];
      end
    end
  end

  assign en_s = en_sync_q[NUM_STAGES-1];

  // Delayed copy of the synchronised enable, used for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_d_q <= 1'b0;
    end else begin
      en_d_q <= en_s;
    end
  end

  // In level mode, only a rise counts. In toggle mode, either edge counts.
  if (EN_MODE == 0) begin : g_level
    assign evt = en_s & ~en_d_q;
  end else begin : g_toggle
    assign evt = en_s ^ en_d_q;
  end

  // Handshake and capture state.
  logic [WIDTH-1:0] sync_bus_q, sync_bus_d;
  logic             sync_valid_q, sync_valid_d;
  logic             enable_pulse_q, enable_pulse_d;
  logic             overrun_q, overrun_d;
  logic [CNT_W-1:0] event_cnt_q, event_cnt_d;

  logic consume;
  logic load;
  logic drop;

  // A consumer taking the current word frees the slot for a same-cycle load.
  assign consume = sync_valid_q & sync_ready;
  assign load    = evt & (~sync_valid_q | sync_ready);
  assign drop    = evt & sync_valid_q & ~sync_ready;

  // Next-state logic for capture, handshake, overrun and the load counter.
  always_comb begin
    sync_bus_d     = sync_bus_q;
    sync_valid_d   = sync_valid_q;
    enable_pulse_d = load;
    overrun_d      = overrun_q;
    event_cnt_d    = event_cnt_q;

    if (load) begin
      sync_bus_d   = unsync_bus;
      sync_valid_d = 1'b1;
      if (event_cnt_q != CNT_MAX) begin
        event_cnt_d = event_cnt_q + CNT_ONE;
      end
    end else if (consume) begin
      sync_valid_d = 1'b0;
    end

    // A drop in the same cycle as a clear leaves the flag set.
    if (drop) begin
      overrun_d = 1'b1;
    end else if (clr_ovr) begin
      overrun_d = 1'b0;
    end
  end

  // Registered outputs. The state clears as soon as reset asserts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_bus_q     <= '0;
      sync_valid_q   <= 1'b0;
      enable_pulse_q <= 1'b0;
      overrun_q      <= 1'b0;
      event_cnt_q    <= '0;
    end else begin
      sync_bus_q     <= sync_bus_d;
      sync_valid_q   <= sync_valid_d;
      enable_pulse_q <= enable_pulse_d;
      overrun_q      <= overrun_d;
      event_cnt_q    <= event_cnt_d;
    end
  end

  assign sync_bus     = sync_bus_q;
  assign sync_valid   = sync_valid_q;
  assign enable_pulse = enable_pulse_q;
  assign overrun      = overrun_q;
  assign event_cnt    = event_cnt_q;

endmodule

// File: tb/tb_bus_sync_en.sv
// Testbench for bus_sync_en.
// Instance A runs in level mode with a 2-bit counter.
// Instance B runs in toggle mode with an 8-bit counter.
// Expected loads are queued when the stimulus is issued. A monitor pops one
// entry on every enable_pulse and compares it with the instance outputs.
module tb_bus_sync_en;

  logic       clk;
  logic       reset_n;

  logic [7:0] a_bus, a_sbus;
  logic       a_en, a_rdy, a_clr, a_valid, a_pulse, a_ovr;
  logic [1:0] a_cnt;

  logic [7:0] b_bus, b_sbus;
  logic       b_en, b_rdy, b_clr, b_valid, b_pulse, b_ovr;
  logic [7:0] b_cnt;

  int errors = 0;
  int checks = 0;

  logic [7:0] a_q_data[$];
  int         a_q_cnt[$];
  logic [7:0] b_q_data[$];
  int         b_q_cnt[$];
  int         a_cnt_m = 0;
  int         b_cnt_m = 0;

  logic [7:0] tdata [4];

  bus_sync_en #(.WIDTH(8), .NUM_STAGES(2), .EN_MODE(0), .CNT_W(2)) u_a (
    .clk(clk), .reset_n(reset_n), .unsync_bus(a_bus), .bus_enable(a_en),
    .sync_ready(a_rdy), .clr_ovr(a_clr), .sync_bus(a_sbus), .sync_valid(a_valid),
    .enable_pulse(a_pulse), .overrun(a_ovr), .event_cnt(a_cnt)
  );

  bus_sync_en #(.WIDTH(8), .NUM_STAGES(2), .EN_MODE(1), .CNT_W(8)) u_b (
    .clk(clk), .reset_n(reset_n), .unsync_bus(b_bus), .bus_enable(b_en),
    .sync_ready(b_rdy), .clr_ovr(b_clr), .sync_bus(b_sbus), .sync_valid(b_valid),
    .enable_pulse(b_pulse), .overrun(b_ovr), .event_cnt(b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Inputs change 2 time units after a rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push_a(input logic [7:0] d);
    a_cnt_m = (a_cnt_m == 3) ? 3 : a_cnt_m + 1;
    a_q_data.push_back(d);
    a_q_cnt.push_back(a_cnt_m);
  endtask

  task automatic push_b(input logic [7:0] d);
    b_cnt_m = (b_cnt_m == 255) ? 255 : b_cnt_m + 1;
    b_q_data.push_back(d);
    b_q_cnt.push_back(b_cnt_m);
  endtask

  // The monitor samples on the falling edge, away from the active edge.
  task automatic monitor();
    logic [7:0] d;
    int         c;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (a_pulse) begin
          if (a_q_data.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL a_unexpected_pulse: got data %0h, expected no pulse", a_sbus);
          end else begin
            d = a_q_data.pop_front();
            c = a_q_cnt.pop_front();
            chk("a_sb_data", 32'(a_sbus), 32'(d));
            chk("a_sb_cnt", 32'(a_cnt), c);
            chk("a_sb_valid", 32'(a_valid), 1);
          end
        end
        if (b_pulse) begin
          if (b_q_data.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL b_unexpected_pulse: got data %0h, expected no pulse", b_sbus);
          end else begin
            d = b_q_data.pop_front();
            c = b_q_cnt.pop_front();
            chk("b_sb_data", 32'(b_sbus), 32'(d));
            chk("b_sb_cnt", 32'(b_cnt), c);
            chk("b_sb_valid", 32'(b_valid), 1);
          end
        end
      end
    end
  endtask

  initial begin
    tdata   = '{8'h11, 8'h22, 8'h33, 8'h44};
    reset_n = 1'b0;
    a_bus = 8'h00; a_en = 1'b0; a_rdy = 1'b1; a_clr = 1'b0;
    b_bus = 8'h00; b_en = 1'b0; b_rdy = 1'b1; b_clr = 1'b0;
    fork
      monitor();
    join_none

    // Check the reset state.
    tick(3);
    chk("rst_a_sbus",  32'(a_sbus), 0);
    chk("rst_a_valid", 32'(a_valid), 0);
    chk("rst_a_pulse", 32'(a_pulse), 0);
    chk("rst_a_ovr",   32'(a_ovr), 0);
    chk("rst_a_cnt",   32'(a_cnt), 0);
    chk("rst_b_valid", 32'(b_valid), 0);
    chk("rst_b_cnt",   32'(b_cnt), 0);
    reset_n = 1'b1;
    tick(2);

    // T1: the load appears exactly after edge 3.
    a_bus = 8'hA5; a_en = 1'b1; push_a(8'hA5);
    tick(1); chk("t1_pulse_e1", 32'(a_pulse), 0);
    tick(1); chk("t1_pulse_e2", 32'(a_pulse), 0);
    tick(1);
    chk("t1_pulse_e3", 32'(a_pulse), 1);
    chk("t1_sbus",     32'(a_sbus), 32'h A5);
    chk("t1_valid",    32'(a_valid), 1);
    chk("t1_cnt",      32'(a_cnt), 1);

    // T2: the level is held, then falls. No further load is expected.
    tick(1); a_bus = 8'hFF;
    tick(16); a_en = 1'b0;
    tick(6);
    chk("t2_hold_sbus", 32'(a_sbus), 32'h A5);
    chk("t2_valid",     32'(a_valid), 0);
    chk("t2_cnt",       32'(a_cnt), 1);

    // T4: an event arrives while the word is unconsumed, so it is dropped.
    a_rdy = 1'b0; a_bus = 8'h11; a_en = 1'b1; push_a(8'h11);
    tick(5);
    a_en = 1'b0; tick(3);
    a_bus = 8'h22; a_en = 1'b1;
    tick(5);
    chk("t4_sbus",  32'(a_sbus), 32'h11);
    chk("t4_ovr",   32'(a_ovr), 1);
    chk("t4_valid", 32'(a_valid), 1);
    chk("t4_cnt",   32'(a_cnt), 2);
    a_clr = 1'b1; tick(1); a_clr = 1'b0;
    chk("t4_clr_alone", 32'(a_ovr), 0);
    a_en = 1'b0; tick(3);
    a_bus = 8'h33; a_en = 1'b1;
    tick(2); a_clr = 1'b1;
    tick(1); a_clr = 1'b0;
    chk("t4_clr_vs_drop", 32'(a_ovr), 1);
    chk("t4_drop_sbus",   32'(a_sbus), 32'h11);

    // T5: an event and a consume occur on the same edge.
    a_clr = 1'b1; tick(1); a_clr = 1'b0;
    a_en = 1'b0; tick(3);
    a_bus = 8'h44; a_en = 1'b1; push_a(8'h44);
    tick(2); a_rdy = 1'b1;
    tick(1);
    chk("t5_valid", 32'(a_valid), 1);
    chk("t5_sbus",  32'(a_sbus), 32'h44);
    chk("t5_ovr",   32'(a_ovr), 0);
    tick(4);

    // The 2-bit counter holds at 3 while loads continue.
    a_en = 1'b0; tick(3);
    a_bus = 8'h55; a_en = 1'b1; push_a(8'h55); tick(5);
    a_en = 1'b0; tick(3);
    a_bus = 8'h66; a_en = 1'b1; push_a(8'h66); tick(5);
    chk("t6_sat_cnt",  32'(a_cnt), 3);
    chk("t6_sat_sbus", 32'(a_sbus), 32'h66);

    // T3: toggle mode on instance B.
    for (int k = 0; k < 4; k++) begin
      b_bus = tdata[k];
      b_en  = ~b_en;
      push_b(tdata[k]);
      tick(6);
    end
    chk("t3_cnt",  32'(b_cnt), 4);
    chk("t3_sbus", 32'(b_sbus), 32'h44);

    // T6: reset arrives while an edge is in flight. The reset is seen immediately.
    b_bus = 8'h77; b_en = 1'b1;
    tick(1);
    reset_n = 1'b0;
    #1;
    chk("t6_b_pulse", 32'(b_pulse), 0);
    chk("t6_b_valid", 32'(b_valid), 0);
    chk("t6_b_cnt",   32'(b_cnt), 0);
    chk("t6_b_sbus",  32'(b_sbus), 0);
    chk("t6_a_cnt",   32'(a_cnt), 0);
    chk("t6_a_sbus",  32'(a_sbus), 0);
    b_en    = 1'b0;
    a_cnt_m = 0;
    b_cnt_m = 0;
    tick(2);
    reset_n = 1'b1;
    // Instance A still sees a high level, so it captures the word again.
    push_a(8'h66);
    tick(6);
    chk("t6_b_no_load", 32'(b_cnt), 0);
    chk("t6_b_valid2",  32'(b_valid), 0);
    chk("t6_a_recap",   32'(a_cnt), 1);
    chk("t6_a_sbus2",   32'(a_sbus), 32'h66);

    chk("a_sb_empty", a_q_data.size(), 0);
    chk("b_sb_empty", b_q_data.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
